// File: rtl/spike_rate_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : spike_rate_monitor                                               |
// | Brief   : Windowed spike rate, inter-spike interval and burst detection.   |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module spike_rate_monitor #(
  parameter int CNT_W        = 8,
  parameter int WIN_MIN_LOG2 = 4,
  parameter int WIN_W        = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             spike,
  input  logic [2:0]       window_sel,
  input  logic [CNT_W-1:0] burst_thresh,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  output logic [CNT_W-1:0] isi_out,
  output logic             isi_valid,
  output logic             burst
);

  localparam logic [1:0]       S_IDLE    = 2'd0;
  localparam logic [1:0]       S_ARMED   = 2'd1;
  localparam logic [1:0]       S_BURST   = 2'd2;
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic             r_spike_d;
  logic [WIN_W-1:0] r_win_cnt;
  logic [2:0]       r_cur_win_sel;
  logic [CNT_W-1:0] r_spike_cnt;
  logic [CNT_W-1:0] r_isi_timer;
  logic [CNT_W-1:0] r_rate_out;
  logic             r_rate_valid;
  logic [CNT_W-1:0] r_isi_out;
  logic             r_isi_valid;
  logic [1:0]       r_state;

  logic             w_event;
  logic [WIN_W:0]   w_win_len;
  logic [WIN_W-1:0] w_win_last_idx;
  logic             w_win_last;
  logic [CNT_W:0]   w_cnt_sum;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W:0]   w_isi_sum;
  logic [CNT_W-1:0] w_isi_next;
  logic             w_isi_report;
  logic [1:0]       w_next_state;
  logic             w_burst;

  assign w_event        = ena & spike & ~r_spike_d;
  assign w_win_len      = (WIN_W+1)'(1) << (WIN_MIN_LOG2 + int'(r_cur_win_sel));
  assign w_win_last_idx = WIN_W'(w_win_len - (WIN_W+1)'(1));
  assign w_win_last     = (r_win_cnt == w_win_last_idx);

  assign w_cnt_sum  = {1'b0, r_spike_cnt} + {{CNT_W{1'b0}}, w_event};
  assign w_cnt_next = w_cnt_sum[CNT_W] ? C_CNT_MAX : w_cnt_sum[CNT_W-1:0];
  assign w_isi_sum  = {1'b0, r_isi_timer} + (CNT_W+1)'(1);
  assign w_isi_next = w_isi_sum[CNT_W] ? C_CNT_MAX : w_isi_sum[CNT_W-1:0];

  // The first event after IDLE has no predecessor, so no interval is reported.
  assign w_isi_report = w_event & (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spike_d     <= 1'b0;
      r_win_cnt     <= '0;
      r_cur_win_sel <= '0;
      r_spike_cnt   <= '0;
      r_isi_timer   <= '0;
      r_rate_out    <= '0;
      r_rate_valid  <= 1'b0;
      r_isi_out     <= '0;
      r_isi_valid   <= 1'b0;
    end else if (ena) begin
      r_spike_d    <= spike;
      r_rate_valid <= w_win_last;
      r_isi_valid  <= w_isi_report;
      if (w_win_last) begin
        r_win_cnt     <= '0;
        r_cur_win_sel <= window_sel;
        r_rate_out    <= w_cnt_next;
        r_spike_cnt   <= '0;
      end else begin
        r_win_cnt   <= r_win_cnt + WIN_W'(1);
        r_spike_cnt <= w_cnt_next;
      end
      if (w_event) begin
        r_isi_timer <= CNT_W'(1);
      end else if (r_state != S_IDLE) begin
        r_isi_timer <= w_isi_next;
      end
      if (w_isi_report) begin
        r_isi_out <= r_isi_timer;
      end
    end else begin
      // Pulses must not stretch across a disabled stretch.
      r_rate_valid <= 1'b0;
      r_isi_valid  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else if (ena) begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_event) w_next_state = S_ARMED;
      end
      S_ARMED: begin
        if (w_event && (r_isi_timer <= burst_thresh)) w_next_state = S_BURST;
      end
      S_BURST: begin
        if (r_isi_timer > burst_thresh) w_next_state = S_ARMED;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_burst = (r_state == S_BURST);
  end

  assign rate_out   = r_rate_out;
  assign rate_valid = r_rate_valid;
  assign isi_out    = r_isi_out;
  assign isi_valid  = r_isi_valid;
  assign burst      = w_burst;

endmodule
`default_nettype wire

// File: tb/tb_spike_rate_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_spike_rate_monitor                                            |
// | Brief   : Directed self-checking bench for spike_rate_monitor.             |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_spike_rate_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ena = 1'b1;
  logic       spike = 1'b0;
  logic [2:0] window_sel = 3'd0;
  logic [7:0] burst_thresh = 8'd0;
  logic [7:0] rate_out;
  logic       rate_valid;
  logic [7:0] isi_out;
  logic       isi_valid;
  logic       burst;

  int n_vec = 0;
  int n_err = 0;

  spike_rate_monitor #(.CNT_W(8), .WIN_MIN_LOG2(4), .WIN_W(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .spike        (spike),
    .window_sel   (window_sel),
    .burst_thresh (burst_thresh),
    .rate_out     (rate_out),
    .rate_valid   (rate_valid),
    .isi_out      (isi_out),
    .isi_valid    (isi_valid),
    .burst        (burst)
  );

  always #5 clk = ~clk;

  // Inputs applied 1ns after a rising edge; outputs read at the same point.
  task automatic step(input logic spk);
    spike = spk;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    spike = 1'b0;
    ena   = 1'b1;
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (rate_out !== 8'd0)   begin n_err++; $display("FAIL reset_rate_out: got %0d expected 0", rate_out); end
    n_vec++; if (rate_valid !== 1'b0) begin n_err++; $display("FAIL reset_rate_valid: got %b expected 0", rate_valid); end
    n_vec++; if (isi_out !== 8'd0)    begin n_err++; $display("FAIL reset_isi_out: got %0d expected 0", isi_out); end
    n_vec++; if (isi_valid !== 1'b0)  begin n_err++; $display("FAIL reset_isi_valid: got %b expected 0", isi_valid); end
    n_vec++; if (burst !== 1'b0)      begin n_err++; $display("FAIL reset_burst: got %b expected 0", burst); end
  endtask

  task automatic test_basic_rate();
    int isi_cnt = 0;
    window_sel = 3'd0; burst_thresh = 8'd0;
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      step(c == 2 || c == 6 || c == 10 || c == 14);
      if (isi_valid) begin
        isi_cnt++;
        n_vec++; if (isi_out !== 8'd4) begin n_err++; $display("FAIL basic_isi: edge %0d got %0d expected 4", c, isi_out); end
      end
      n_vec++;
      if (rate_valid !== (c == 16)) begin n_err++; $display("FAIL basic_rate_valid: edge %0d got %b expected %b", c, rate_valid, c == 16); end
    end
    n_vec++; if (rate_out !== 8'd4) begin n_err++; $display("FAIL basic_rate_out: got %0d expected 4", rate_out); end
    n_vec++; if (isi_cnt != 3)      begin n_err++; $display("FAIL basic_isi_count: got %0d expected 3", isi_cnt); end
    n_vec++; if (burst !== 1'b0)    begin n_err++; $display("FAIL basic_no_burst: got %b expected 0", burst); end
    step(1'b0);
    n_vec++; if (rate_valid !== 1'b0) begin n_err++; $display("FAIL basic_valid_one_cycle: got %b expected 0", rate_valid); end
  endtask

  task automatic test_held_spike();
    int isi_cnt = 0;
    window_sel = 3'd0;
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      step(c <= 10);
      if (isi_valid) isi_cnt++;
    end
    n_vec++; if (rate_valid !== 1'b1) begin n_err++; $display("FAIL held_rate_valid: got %b expected 1", rate_valid); end
    n_vec++; if (rate_out !== 8'd1)   begin n_err++; $display("FAIL held_rate_out: got %0d expected 1", rate_out); end
    n_vec++; if (isi_cnt != 0)        begin n_err++; $display("FAIL held_isi_count: got %0d expected 0", isi_cnt); end
  endtask

  task automatic test_saturation();
    window_sel = 3'd7; burst_thresh = 8'd3;
    do_reset();
    for (int c = 1; c <= 16; c++) step(1'b0);
    n_vec++; if (rate_valid !== 1'b1) begin n_err++; $display("FAIL sat_first_window: got %b expected 1", rate_valid); end
    for (int k = 1; k <= 2048; k++) begin
      step(k % 2 == 1);
      if (isi_valid) begin
        n_vec++; if (isi_out !== 8'd2) begin n_err++; $display("FAIL sat_isi: step %0d got %0d expected 2", k, isi_out); end
      end
      if (k == 2047) begin
        n_vec++; if (rate_valid !== 1'b0) begin n_err++; $display("FAIL sat_early_valid: got %b expected 0", rate_valid); end
      end
    end
    n_vec++; if (rate_valid !== 1'b1) begin n_err++; $display("FAIL sat_rate_valid: got %b expected 1", rate_valid); end
    n_vec++; if (rate_out !== 8'd255) begin n_err++; $display("FAIL sat_rate_out: got %0d expected 255", rate_out); end
    n_vec++; if (burst !== 1'b1)      begin n_err++; $display("FAIL sat_burst: got %b expected 1", burst); end
  endtask

  task automatic test_burst();
    window_sel = 3'd0; burst_thresh = 8'd5;
    do_reset();
    for (int e = 1; e <= 13; e++) begin
      step(e == 1 || e == 4 || e == 7);
      if (e == 1) begin
        n_vec++; if (burst !== 1'b0) begin n_err++; $display("FAIL burst_first_event: got %b expected 0", burst); end
      end
      if (e == 4) begin
        n_vec++; if (burst !== 1'b1)     begin n_err++; $display("FAIL burst_rise: got %b expected 1", burst); end
        n_vec++; if (isi_out !== 8'd3)   begin n_err++; $display("FAIL burst_isi: got %0d expected 3", isi_out); end
        n_vec++; if (isi_valid !== 1'b1) begin n_err++; $display("FAIL burst_isi_valid: got %b expected 1", isi_valid); end
      end
      if (e == 12) begin
        n_vec++; if (burst !== 1'b1) begin n_err++; $display("FAIL burst_hold: got %b expected 1", burst); end
      end
    end
    n_vec++; if (burst !== 1'b0) begin n_err++; $display("FAIL burst_fall: got %b expected 0", burst); end
    for (int e = 14; e <= 307; e++) step(e == 307);
    n_vec++; if (isi_valid !== 1'b1) begin n_err++; $display("FAIL long_isi_valid: got %b expected 1", isi_valid); end
    n_vec++; if (isi_out !== 8'd255) begin n_err++; $display("FAIL long_isi_sat: got %0d expected 255", isi_out); end
    n_vec++; if (burst !== 1'b0)     begin n_err++; $display("FAIL long_isi_burst: got %b expected 0", burst); end
  endtask

  task automatic test_wrap_event();
    int pulses = 0;
    window_sel = 3'd0; burst_thresh = 8'd0;
    do_reset();
    for (int e = 1; e <= 64; e++) begin
      window_sel = (e >= 20) ? 3'd1 : 3'd0;
      step(e == 25 || e == 32 || e == 40);
      if (e == 32) begin
        n_vec++; if (rate_valid !== 1'b1) begin n_err++; $display("FAIL wrap_valid: got %b expected 1", rate_valid); end
        n_vec++; if (rate_out !== 8'd2)   begin n_err++; $display("FAIL wrap_event_counted: got %0d expected 2", rate_out); end
      end
      if (e > 32 && e < 64 && rate_valid) pulses++;
    end
    n_vec++; if (pulses != 0)          begin n_err++; $display("FAIL wrap_new_len_early: got %0d pulses expected 0", pulses); end
    n_vec++; if (rate_valid !== 1'b1)  begin n_err++; $display("FAIL wrap_new_len_end: got %b expected 1", rate_valid); end
    n_vec++; if (rate_out !== 8'd1)    begin n_err++; $display("FAIL wrap_next_rate: got %0d expected 1", rate_out); end
  endtask

  task automatic test_ena_freeze();
    int pulses = 0;
    window_sel = 3'd0; burst_thresh = 8'd0;
    do_reset();
    for (int e = 1; e <= 5; e++) step(e == 2);
    ena = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step(c % 2 == 0);
      if (rate_valid || isi_valid) pulses++;
    end
    ena = 1'b1;
    n_vec++; if (pulses != 0) begin n_err++; $display("FAIL ena_pulses: got %0d expected 0", pulses); end
    for (int e = 6; e <= 16; e++) begin
      step(e == 10);
      if (e == 10) begin
        n_vec++; if (isi_out !== 8'd8) begin n_err++; $display("FAIL ena_isi: got %0d expected 8", isi_out); end
      end
      if (e == 15) begin
        n_vec++; if (rate_valid !== 1'b0) begin n_err++; $display("FAIL ena_win_early: got %b expected 0", rate_valid); end
      end
    end
    n_vec++; if (rate_valid !== 1'b1) begin n_err++; $display("FAIL ena_win_end: got %b expected 1", rate_valid); end
    n_vec++; if (rate_out !== 8'd2)   begin n_err++; $display("FAIL ena_rate: got %0d expected 2", rate_out); end
  endtask

  task automatic test_reset_midrun();
    window_sel = 3'd0; burst_thresh = 8'd10;
    do_reset();
    for (int e = 1; e <= 10; e++) step(e % 2 == 1);
    n_vec++; if (burst !== 1'b1)   begin n_err++; $display("FAIL midrun_pre_burst: got %b expected 1", burst); end
    n_vec++; if (isi_out !== 8'd2) begin n_err++; $display("FAIL midrun_pre_isi: got %0d expected 2", isi_out); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (burst !== 1'b0)   begin n_err++; $display("FAIL midrun_async_burst: got %b expected 0", burst); end
    n_vec++; if (isi_out !== 8'd0) begin n_err++; $display("FAIL midrun_async_isi: got %0d expected 0", isi_out); end
    #2;
    rst_n = 1'b1;
    step(1'b1);
    n_vec++; if (isi_valid !== 1'b0) begin n_err++; $display("FAIL midrun_first_event: got %b expected 0", isi_valid); end
    step(1'b0);
    step(1'b1);
    n_vec++; if (isi_valid !== 1'b1) begin n_err++; $display("FAIL midrun_second_event: got %b expected 1", isi_valid); end
    for (int e = 4; e <= 16; e++) step(1'b0);
    n_vec++; if (rate_out !== 8'd2) begin n_err++; $display("FAIL midrun_rate: got %0d expected 2", rate_out); end
  endtask

  initial begin
    test_reset();
    test_basic_rate();
    test_held_spike();
    test_saturation();
    test_burst();
    test_wrap_event();
    test_ena_freeze();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_rate_monitor.md
Name: spike_rate_monitor

Overview:
Downstream stage of the LIF neuron. It consumes the neuron's spike output and measures firing behaviour. Per-window spike rate, last inter-spike interval (ISI) and a burst flag are latched for the top-level to drive onto uo_out/uio_out. It sits beside the neuron inside the tt_um wrapper and shares its clock, reset and ena.

Parameters:
CNT_W, 8, width of rate count and ISI registers; both saturate at 2^CNT_W-1.
WIN_MIN_LOG2, 4, log2 of the shortest window; window length L = 2^(WIN_MIN_LOG2 + window_sel).
WIN_W, 12, width of window cycle counter; must hold L-1 for window_sel=7.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  design enable; low freezes all state
spike  input  1  neuron spike level, synchronous to clk
window_sel  input  3  window length select
burst_thresh  input  CNT_W  max ISI (cycles) counted as burst
rate_out  output  CNT_W  spikes counted in last completed window
rate_valid  output  1  one-cycle pulse when rate_out updates
isi_out  output  CNT_W  cycles between the last two spike events
isi_valid  output  1  one-cycle pulse when isi_out updates
burst  output  1  high while in BURST state

Behaviour:
- Reset (async, rst_n=0): all outputs 0; spike_d=0; win_cnt=0; spike_cnt=0; isi_timer=0; state=IDLE; cur_win_sel=0.
- Event: ena=1 and spike=1 and spike_d=0 at a rising clk edge. spike_d <= spike on every enabled edge. A spike held high counts once.
- ena=0: no register changes except rst_n. No events, no valid pulses. Counters resume on re-enable with no loss.
- Window: win_cnt counts 0..L-1, with L taken from cur_win_sel. cur_win_sel <= window_sel only on the edge where win_cnt wraps to 0. Mid-window changes apply from the next window.
- On the edge where win_cnt==L-1:
  - rate_out <= sat(spike_cnt + event).
  - spike_cnt <= 0.
  - win_cnt <= 0.
  - rate_valid <= 1 for that one cycle.
- Otherwise: spike_cnt <= sat(spike_cnt + event).
- Saturation: any sum above 2^CNT_W-1 clamps to 2^CNT_W-1.
- ISI timer:
  - On an event: isi_timer <= 1.
  - Else, if state != IDLE: isi_timer <= sat(isi_timer+1).
  - Two events d cycles apart therefore give isi_out = d (clamped).
- State machine IDLE / ARMED / BURST:
  - IDLE: on event -> ARMED. isi_valid is not pulsed; there is no previous spike.
  - ARMED: on event -> isi_out <= isi_timer, isi_valid pulse. Go to BURST if isi_timer <= burst_thresh, else stay ARMED.
  - BURST: on event -> isi_out/isi_valid as in ARMED. Stay in BURST if isi_timer <= burst_thresh, else go to ARMED. With no event, once isi_timer > burst_thresh -> ARMED.
  - burst = (state==BURST), registered.
- burst_thresh=0 never enters BURST, because the minimum ISI is 2.
- Simultaneous window end and event: the event is included in the closing window's rate_out. The new window starts at 0.
- Outputs are registered. The valid pulses assert in the cycle after the triggering edge and last exactly one cycle.

Test Plan:
- Reset mid-run: rst_n low while spike_cnt=5 and state=BURST. All outputs go 0 immediately (async). After release, the first event gives no isi_valid.
- window_sel=0 (L=16), spike pulses at cycles 2, 6, 10, 14. Result: rate_out=4 with rate_valid after the 16th edge. ISI=4 reported three times.
- Spike held high for 10 cycles, then low. Result: exactly one event, and rate_out=1 for that window.
- window_sel=7 (L=2048), spike toggled every 2 cycles (1024 events). Result: rate_out=255 (saturated). ISI=2, and burst=1 with burst_thresh=3.
- burst_thresh=5, ISIs of 3,3 then silence. Result: burst rises after the second event and falls when isi_timer reaches 6. A subsequent ISI of 300 gives isi_out=255.
- Event on the window-wrap edge plus window_sel changed mid-window. The event is counted in the closing window, and the new length applies only to the next window.
- ena=0 for 20 cycles mid-window with spike toggling. No counts, no valid pulses, and win_cnt unchanged.
